// File: rtl/imem_loader_if.sv
// Byte-stream in / IMEM write port out, plus load status, for the program loader.
interface imem_loader_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       last_pc;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, we, waddr, wdata, cpu_rst, busy, done, err, last_pc
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, we, waddr, wdata, cpu_rst, busy, done, err, last_pc
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: framed byte stream (word count, then words, MSB first) -> IMEM writes,
// holding the CPU in reset while loading or after a rejected image.
module imem_loader #(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input logic          i_clk_in,
  input logic          i_reset,
  imem_loader_if.slave io_ldr
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

  localparam logic [31:0] CAP_WORDS = 32'd1 << ADDR_W;

  state_t            r_state, w_nxt;
  logic [31:0]       r_cnt;
  logic [31:0]       r_word;
  logic [1:0]        r_bcnt;
  logic [ADDR_W:0]   r_widx;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_last_pc;

  logic        w_busy, w_acc, w_byte4, w_last, w_over;
  logic [31:0] w_hdr, w_word, w_widx32;

  assign w_busy   = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_acc    = io_ldr.in_valid && w_busy;
  assign w_byte4  = w_acc && (r_bcnt == 2'd3);
  assign w_hdr    = {r_cnt[23:0], io_ldr.in_data};
  assign w_word   = {r_word[23:0], io_ldr.in_data};
  assign w_widx32 = 32'(r_widx);
  // r_cnt is nonzero and <= capacity in DATA, so cnt-1 cannot underflow
  assign w_last   = (w_widx32 + 32'd1) == r_cnt;
  assign w_over   = w_hdr > CAP_WORDS;

  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (io_ldr.start) w_nxt = S_HDR;
      S_HDR: begin
        if (w_byte4) begin
          if (w_hdr == 32'd0) w_nxt = S_DONE;
          else if (w_over)    w_nxt = S_ERR;
          else                w_nxt = S_DATA;
        end
      end
      S_DATA:  if (w_byte4 && w_last) w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_word    <= '0;
      r_bcnt    <= '0;
      r_widx    <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_last_pc <= BASE_ADDR;
    end else begin
      r_we   <= 1'b0;
      r_done <= (w_nxt == S_DONE);
      r_err  <= (w_nxt == S_ERR);
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (io_ldr.start) begin
            r_cnt  <= '0;
            r_bcnt <= '0;
            r_widx <= '0;
          end
        end
        S_HDR: begin
          if (w_acc) begin
            r_cnt  <= w_hdr;
            r_bcnt <= r_bcnt + 2'd1;
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_word <= w_word;
            r_bcnt <= r_bcnt + 2'd1;
          end
          if (w_byte4) begin
            r_we      <= 1'b1;
            r_waddr   <= r_widx[ADDR_W-1:0];
            r_wdata   <= w_word;
            r_widx    <= r_widx + {{ADDR_W{1'b0}}, 1'b1};
            r_last_pc <= BASE_ADDR + (w_widx32 << 2);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_ldr.in_ready = w_busy;
  assign io_ldr.we       = r_we;
  assign io_ldr.waddr    = r_waddr;
  assign io_ldr.wdata    = r_wdata;
  assign io_ldr.busy     = w_busy;
  assign io_ldr.done     = r_done;
  assign io_ldr.err      = r_err;
  assign io_ldr.last_pc  = r_last_pc;
  // a rejected image keeps the CPU parked until a later load succeeds
  assign io_ldr.cpu_rst  = i_reset || w_busy || r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, gaps, header limits, mid-load reset, start-while-busy.
module tb_imem_loader;
  localparam int ADDR_W = 11;

  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;

  logic [ADDR_W-1:0] q_addr[$];
  logic [31:0]       q_data[$];
  logic [7:0]        frm[$];
  logic              rdy_drop;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0040_0000)) dut (
    .i_clk_in (clk),
    .i_reset  (rst),
    .io_ldr   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.we) begin
      q_addr.push_back(bus.waddr);
      q_data.push_back(bus.wdata);
    end
    if (bus.busy && !bus.in_ready) rdy_drop = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL send_byte_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_frm(input int gap);
    foreach (frm[i]) begin
      send_byte(frm[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic load_demo_frame();
    frm = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h0D};
  endtask

  task automatic check_demo_writes(input string tag);
    checks++;
    if (q_addr.size() !== 2) begin
      errs++;
      $display("FAIL %s_wcount: got %0d writes, required 2", tag, q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 11'd0 || q_data[0] !== 32'h2008_0005) begin
        errs++;
        $display("FAIL %s_w0: got addr=%0d data=%h, required addr=0 data=20080005", tag, q_addr[0], q_data[0]);
      end
      checks++;
      if (q_addr[1] !== 11'd1 || q_data[1] !== 32'h0000_000D) begin
        errs++;
        $display("FAIL %s_w1: got addr=%0d data=%h, required addr=1 data=0000000d", tag, q_addr[1], q_data[1]);
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.cpu_rst !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL %s_status: got done=%b err=%b cpu_rst=%b busy=%b, required 1 0 0 0",
               tag, bus.done, bus.err, bus.cpu_rst, bus.busy);
    end
    checks++;
    if (bus.last_pc !== 32'h0040_0004) begin
      errs++;
      $display("FAIL %s_last_pc: got %h, required 00400004", tag, bus.last_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.we !== 1'b0 || bus.waddr !== '0 || bus.wdata !== 32'h0) begin
      errs++;
      $display("FAIL reset_wport: got we=%b waddr=%0d wdata=%h, required 0 0 0", bus.we, bus.waddr, bus.wdata);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_status: got done=%b err=%b busy=%b in_ready=%b, required all 0",
               bus.done, bus.err, bus.busy, bus.in_ready);
    end
    checks++;
    if (bus.cpu_rst !== 1'b1 || bus.last_pc !== 32'h0040_0000) begin
      errs++;
      $display("FAIL reset_cpu: got cpu_rst=%b last_pc=%h, required 1 00400000", bus.cpu_rst, bus.last_pc);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rst !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got cpu_rst=%b, required 0", bus.cpu_rst);
    end
  endtask

  task automatic test_basic();
    q_addr.delete(); q_data.delete();
    load_demo_frame();
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.cpu_rst !== 1'b1) begin
      errs++;
      $display("FAIL basic_busy: got busy=%b cpu_rst=%b, required 1 1", bus.busy, bus.cpu_rst);
    end
    send_frm(0);
    checks++;
    if (bus.we !== 1'b1 || bus.done !== 1'b1) begin
      errs++;
      $display("FAIL basic_final_we: got we=%b done=%b, required 1 1", bus.we, bus.done);
    end
    idle(2);
    check_demo_writes("basic");
  endtask

  task automatic test_gaps();
    q_addr.delete(); q_data.delete();
    load_demo_frame();
    pulse_start();
    rdy_drop = 1'b0;
    send_frm(3);
    idle(2);
    checks++;
    if (rdy_drop !== 1'b0) begin
      errs++;
      $display("FAIL gaps_ready: in_ready dropped while busy, required steady 1");
    end
    check_demo_writes("gaps");
  endtask

  task automatic test_hdr_overflow();
    q_addr.delete(); q_data.delete();
    frm = '{8'h00, 8'h00, 8'h08, 8'h01};
    pulse_start();
    send_frm(0);
    idle(3);
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL ovf_status: got err=%b done=%b cpu_rst=%b in_ready=%b, required 1 0 1 0",
               bus.err, bus.done, bus.cpu_rst, bus.in_ready);
    end
    checks++;
    if (q_addr.size() !== 0) begin
      errs++;
      $display("FAIL ovf_writes: got %0d writes, required 0", q_addr.size());
    end
    load_demo_frame();
    pulse_start();
    checks++;
    if (bus.cpu_rst !== 1'b1 || bus.err !== 1'b0) begin
      errs++;
      $display("FAIL ovf_restart: got cpu_rst=%b err=%b, required 1 0", bus.cpu_rst, bus.err);
    end
    send_frm(0);
    idle(2);
    check_demo_writes("ovf_reload");
  endtask

  task automatic test_zero();
    q_addr.delete(); q_data.delete();
    frm = '{8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frm(0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_rst !== 1'b0 || bus.err !== 1'b0) begin
      errs++;
      $display("FAIL zero_status: got done=%b busy=%b cpu_rst=%b err=%b, required 1 0 0 0",
               bus.done, bus.busy, bus.cpu_rst, bus.err);
    end
    idle(2);
    checks++;
    if (q_addr.size() !== 0) begin
      errs++;
      $display("FAIL zero_writes: got %0d writes, required 0", q_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    load_demo_frame();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(frm[i]);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_async: got we=%b busy=%b cpu_rst=%b in_ready=%b, required 0 0 1 0",
               bus.we, bus.busy, bus.cpu_rst, bus.in_ready);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.cpu_rst !== 1'b0 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_release: got done=%b cpu_rst=%b in_ready=%b, required 0 0 0",
               bus.done, bus.cpu_rst, bus.in_ready);
    end
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(frm[i]);
    checks++;
    if (bus.we !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_we_pre: got we=%b, required 1", bus.we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.we !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_we_drop: got we=%b, required 0", bus.we);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_in_data();
    q_addr.delete(); q_data.delete();
    load_demo_frame();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(frm[i]);
    idle(1);
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL sid_busy: got busy=%b, required 1", bus.busy);
    end
    for (int i = 6; i < 12; i++) send_byte(frm[i]);
    idle(2);
    check_demo_writes("start_in_data");
  endtask

  task automatic test_full();
    int bad = 0;
    logic [31:0] w;
    q_addr.delete(); q_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    for (int i = 0; i < 2048; i++) begin
      w = 32'hA500_0000 | i;
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    end
    idle(2);
    checks++;
    if (q_addr.size() !== 2048) begin
      errs++;
      $display("FAIL full_wcount: got %0d writes, required 2048", q_addr.size());
    end else begin
      foreach (q_addr[i])
        if (q_addr[i] !== ADDR_W'(i) || q_data[i] !== (32'hA500_0000 | i)) bad++;
      checks++;
      if (bad !== 0) begin
        errs++;
        $display("FAIL full_contents: got %0d bad writes, required 0", bad);
      end
    end
    checks++;
    if (bus.last_pc !== 32'h0040_1FFC || bus.done !== 1'b1 || bus.err !== 1'b0 || bus.cpu_rst !== 1'b0) begin
      errs++;
      $display("FAIL full_status: got last_pc=%h done=%b err=%b cpu_rst=%b, required 00401ffc 1 0 0",
               bus.last_pc, bus.done, bus.err, bus.cpu_rst);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_hdr_overflow();
    test_zero();
    test_reset_mid();
    test_start_in_data();
    test_full();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
